bit_serial_core: RTL

Parametrised bit-serial accumulator processor. It extends the fixed 8-bit, two-register bit-serial datapath to WIDTH-bit words, NREG general-purpose registers, subtract and flag support. Each instruction runs through a one-bit ALU, LSB first, over WIDTH shift cycles. A start/advance handshake lets the instruction sequencer step the program counter.

---
 rtl/bit_serial_pkg.sv | 54 +++++
 rtl/serial_alu.sv | 60 ++++++
 rtl/bit_serial_core.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/bit_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bit_serial_pkg
// Description : Shared types for the bit-serial accumulator processor:
//               opcode and FSM state enums, opcode field width and opcode
//               classification helpers.
//               Optional feature macro: BIT_SERIAL_SUB_EN (enables SUB).
// Revision    : 1.0 - initial release
// ============================================================================
package bit_serial_pkg;

  localparam int OPW = 3;

  typedef enum logic [OPW-1:0] {
    OP_NOP = 3'b000,
    OP_LDS = 3'b001,
    OP_LDA = 3'b010,
    OP_STA = 3'b011,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101,
    OP_CLR = 3'b110,
    OP_RSV = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Opcodes that need WIDTH shift cycles; the rest finish in one cycle.
  function automatic logic op_is_serial(opcode_t op);
    case (op)
      OP_LDS, OP_LDA, OP_STA, OP_ADD: return 1'b1;
`ifdef BIT_SERIAL_SUB_EN
      OP_SUB: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Opcodes that run through the ALU and update the carry/zero flags.
  function automatic logic op_is_arith(opcode_t op);
    case (op)
      OP_ADD: return 1'b1;
`ifdef BIT_SERIAL_SUB_EN
      OP_SUB: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_alu.sv
`default_nettype none
// ============================================================================
// Module      : serial_alu
// Description : One-bit full adder with carry flop, first-cycle carry-in
//               select, optional b-inversion for subtraction and a serial
//               zero accumulator over the result bits.
//               Optional feature macro: BIT_SERIAL_SUB_EN (adds sub_i).
// Revision    : 1.0 - initial release
// ============================================================================
module serial_alu (
  input  logic clk_i,
  input  logic rst_i,
`ifdef BIT_SERIAL_SUB_EN
  input  logic sub_i,
`endif
  input  logic en_i,
  input  logic first_i,
  input  logic a_i,
  input  logic b_i,
  output logic sum_o,
  output logic carry_o,
  output logic zero_o
);

  logic w_b_eff;
  logic w_cin;
  logic w_cout;
  logic carry_q;
  logic zero_q;

  // Operand conditioning: subtraction is a + ~b + 1, so invert b and force
  // carry-in high on the first bit.
  always_comb begin
`ifdef BIT_SERIAL_SUB_EN
    w_b_eff = b_i ^ sub_i;
    w_cin   = first_i ? sub_i : carry_q;
`else
    w_b_eff = b_i;
    w_cin   = first_i ? 1'b0 : carry_q;
`endif
    sum_o  = a_i ^ w_b_eff ^ w_cin;
    w_cout = (a_i & w_b_eff) | (a_i & w_cin) | (w_b_eff & w_cin);
  end

  // Carry flop and zero accumulator advance once per shifted bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (en_i) begin
      carry_q <= w_cout;
      zero_q  <= (first_i ? 1'b1 : zero_q) & ~sum_o;
    end
  end

  assign carry_o = carry_q;
  assign zero_o  = zero_q;

endmodule
`default_nettype wire

// File: rtl/bit_serial_core.sv
`default_nettype none
// ============================================================================
// Module      : bit_serial_core
// Description : Parametrised bit-serial accumulator processor. Executes one
//               instruction at a time over WIDTH shift cycles, LSB first,
//               with NREG general-purpose registers and carry/zero flags.
//               Optional feature macro: BIT_SERIAL_SUB_EN (SUB opcode).
// Revision    : 1.0 - initial release
// ============================================================================
module bit_serial_core
  import bit_serial_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NREG  = 2,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [OPW+AW-1:0]     i_instr,
  input  logic [WIDTH-1:0]      i_switch,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_pcincr,
  output logic [WIDTH-1:0]      o_acc,
  output logic [NREG*WIDTH-1:0] o_regs,
  output logic                  o_carry,
  output logic                  o_zero
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  opcode_t          op_q, op_d;
  logic [AW-1:0]    ra_q, ra_d;
  logic [WIDTH-1:0] sw_q, sw_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;

  opcode_t          w_in_op;
  logic             w_shift;
  logic             w_first;
  logic             w_src_bit;
  logic             w_alu_sum;
  logic             w_alu_carry;
  logic             w_alu_zero;

  assign w_in_op   = opcode_t'(i_instr[OPW+AW-1:AW]);
  assign w_shift   = (state_q == ST_SHIFT);
  assign w_first   = w_shift && (cnt_q == '0);
  assign w_src_bit = regs_q[ra_q][0];

  serial_alu u_alu (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
`ifdef BIT_SERIAL_SUB_EN
    .sub_i   (op_q == OP_SUB),
`endif
    .en_i    (w_shift),
    .first_i (w_first),
    .a_i     (acc_q[0]),
    .b_i     (w_src_bit),
    .sum_o   (w_alu_sum),
    .carry_o (w_alu_carry),
    .zero_o  (w_alu_zero)
  );

  // FSM state, bit counter and instruction/switch latches.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_NOP;
      ra_q    <= '0;
      sw_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      ra_q    <= ra_d;
      sw_q    <= sw_d;
    end
  end

  // Next-state logic: accept a start in IDLE, count WIDTH shifts, one DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    ra_d    = ra_q;
    sw_d    = sw_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          op_d    = w_in_op;
          ra_d    = i_instr[AW-1:0];
          sw_d    = i_switch;
          cnt_d   = '0;
          state_d = op_is_serial(w_in_op) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        sw_d = {sw_q[0], sw_q[WIDTH-1:1]};
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Architectural state: accumulator, register file and flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      for (int k = 0; k < NREG; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      acc_q   <= acc_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      for (int k = 0; k < NREG; k++) begin
        regs_q[k] <= regs_d[k];
      end
    end
  end

  // Datapath: everything rotates right each shift; the destination takes
  // its new bit into the MSB so it holds the full result after WIDTH shifts.
  always_comb begin
    acc_d   = acc_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    for (int k = 0; k < NREG; k++) begin
      regs_d[k] = regs_q[k];
    end
    case (state_q)
      ST_IDLE: begin
        if (i_start && (w_in_op == OP_CLR)) begin
          acc_d = '0;
        end
      end
      ST_SHIFT: begin
        acc_d = {acc_q[0], acc_q[WIDTH-1:1]};
        for (int k = 0; k < NREG; k++) begin
          regs_d[k] = {regs_q[k][0], regs_q[k][WIDTH-1:1]};
        end
        case (op_q)
          OP_LDS:         regs_d[ra_q][WIDTH-1] = sw_q[0];
          OP_STA:         regs_d[ra_q][WIDTH-1] = acc_q[0];
          OP_LDA:         acc_d[WIDTH-1]        = w_src_bit;
          OP_ADD, OP_SUB: acc_d[WIDTH-1]        = w_alu_sum;
          default:        ;
        endcase
      end
      ST_DONE: begin
        if (op_is_arith(op_q)) begin
          carry_d = w_alu_carry;
          zero_d  = w_alu_zero;
        end
      end
      default: ;
    endcase
  end

  for (genvar k = 0; k < NREG; k++) begin : g_flat
    assign o_regs[k*WIDTH +: WIDTH] = regs_q[k];
  end

  assign o_busy   = (state_q != ST_IDLE);
  assign o_pcincr = (state_q == ST_DONE);
  assign o_acc    = acc_q;
  assign o_carry  = carry_q;
  assign o_zero   = zero_q;

endmodule
`default_nettype wire
